// File: rtl/cofre_acesso_ctrl_if.sv
// cofre_acesso_ctrl_if: keypad comparator, door and lock signals of the vault access controller.
interface cofre_acesso_ctrl_if;
  logic       inicio;
  logic       aceitoID;
  logic       falhaID;
  logic       fecharPorta;
  logic       habilitaEntrada;
  logic       travaAberta;
  logic       bloqueado;
  logic [2:0] tentativasFalhas;
  logic [2:0] estado;
  modport slave (
    input  inicio, aceitoID, falhaID, fecharPorta,
    output habilitaEntrada, travaAberta, bloqueado, tentativasFalhas, estado
  );
  modport master (
    output inicio, aceitoID, falhaID, fecharPorta,
    input  habilitaEntrada, travaAberta, bloqueado, tentativasFalhas, estado
  );
endinterface

// File: rtl/cofre_acesso_ctrl.sv
// cofre_acesso_ctrl: vault access FSM with timed code entry, timed lock release and lockout after repeated failures.
module cofre_acesso_ctrl #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int TEMPO_ENTRADA  = 270000000,
  parameter int TEMPO_ABERTO   = 135000000,
  parameter int TEMPO_BLOQUEIO = 810000000
) (
  input logic clk_27,
  input logic rst_n,
  cofre_acesso_ctrl_if.slave bus
);
  typedef enum logic [2:0] {OCIOSO = 3'd0, ENTRADA = 3'd1, ABERTO = 3'd2, BLOQUEIO = 3'd3} estado_t;
  localparam logic [31:0] FIM_ENTRADA  = 32'(TEMPO_ENTRADA - 1);
  localparam logic [31:0] FIM_ABERTO   = 32'(TEMPO_ABERTO - 1);
  localparam logic [31:0] FIM_BLOQUEIO = 32'(TEMPO_BLOQUEIO - 1);
  localparam logic [2:0]  MAX_T        = 3'(MAX_TENTATIVAS);
  estado_t estadoAtual, proxEstado;
  logic [31:0] timer, limite;
  logic [2:0] tentativas, proxTent;
  logic prevAceito, prevFalha, bordaAceito, bordaFalha;
  logic expirou, aceitou, falhou, ultima;
  logic habilita, trava, bloq;
  assign bordaAceito = bus.aceitoID & ~prevAceito;
  assign bordaFalha  = bus.falhaID & ~prevFalha;
  assign limite  = estadoAtual == ENTRADA ? FIM_ENTRADA : estadoAtual == ABERTO ? FIM_ABERTO : FIM_BLOQUEIO;
  assign expirou = timer == limite;
  // a result edge always wins over a simultaneous timeout
  assign aceitou = bordaAceito & ~bordaFalha;
  assign falhou  = bordaFalha | (~bordaAceito & expirou);
  assign ultima  = tentativas + 3'd1 == MAX_T;
  always_comb begin
    proxEstado = OCIOSO;
    proxTent   = tentativas;
    case (estadoAtual)
      OCIOSO:   proxEstado = bus.inicio ? ENTRADA : OCIOSO;
      ENTRADA: begin
        proxEstado = aceitou ? ABERTO : falhou ? (ultima ? BLOQUEIO : OCIOSO) : ENTRADA;
        proxTent   = aceitou ? 3'd0 : falhou ? tentativas + 3'd1 : tentativas;
      end
      ABERTO:   proxEstado = bus.fecharPorta | expirou ? OCIOSO : ABERTO;
      BLOQUEIO: begin
        proxEstado = expirou ? OCIOSO : BLOQUEIO;
        proxTent   = expirou ? 3'd0 : tentativas;
      end
      default:  proxEstado = OCIOSO;
    endcase
  end
  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      estadoAtual <= OCIOSO;
      tentativas  <= '0;
      timer       <= '0;
      prevAceito  <= 1'b0;
      prevFalha   <= 1'b0;
      habilita    <= 1'b0;
      trava       <= 1'b0;
      bloq        <= 1'b0;
    end else begin
      estadoAtual <= proxEstado;
      tentativas  <= proxTent;
      timer       <= (proxEstado != estadoAtual || estadoAtual == OCIOSO) ? '0 : timer + 32'd1;
      prevAceito  <= bus.aceitoID;
      prevFalha   <= bus.falhaID;
      habilita    <= proxEstado == ENTRADA;
      trava       <= proxEstado == ABERTO;
      bloq        <= proxEstado == BLOQUEIO;
    end
  end
  assign bus.estado           = estadoAtual;
  assign bus.tentativasFalhas = tentativas;
  assign bus.habilitaEntrada  = habilita;
  assign bus.travaAberta      = trava;
  assign bus.bloqueado        = bloq;
endmodule

// File: tb/tb_cofre_acesso_ctrl.sv
// tb_cofre_acesso_ctrl: vector table, directed corner sequences and random stimulus against a countdown model.
module tb_cofre_acesso_ctrl;
  localparam int MAXT = 3, TE = 20, TA = 10, TB = 16;
  logic clk_27 = 1'b0;
  logic rst_n = 1'b1;
  cofre_acesso_ctrl_if bus();
  cofre_acesso_ctrl #(
    .MAX_TENTATIVAS(MAXT), .TEMPO_ENTRADA(TE), .TEMPO_ABERTO(TA), .TEMPO_BLOQUEIO(TB)
  ) dut (
    .clk_27(clk_27), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk_27 = ~clk_27;
  typedef struct packed {
    logic inicio, aceito, falha, fechar;
    logic [2:0] est, tent;
  } vetor_t;
  vetor_t tabela [12];
  int vectors = 0, miscompares = 0;
  int mEst, mTent, restante;
  bit mPrevA, mPrevF;
  int nHab, nTrava, nBloq;
  function automatic logic [8:0] saida();
    return {bus.habilitaEntrada, bus.travaAberta, bus.bloqueado, bus.tentativasFalhas, bus.estado};
  endfunction
  function automatic logic [8:0] esperado(int e, int t);
    return {e == 1, e == 2, e == 3, 3'(t), 3'(e)};
  endfunction
  task automatic confere(string nome, logic [8:0] atual, logic [8:0] esp);
    vectors++;
    if (atual !== esp) begin
      miscompares++;
      $display("FAIL %s: dut=%b esperado=%b", nome, atual, esp);
    end
  endtask
  task automatic confereInt(string nome, int atual, int esp);
    vectors++;
    if (atual != esp) begin
      miscompares++;
      $display("FAIL %s: dut=%0d esperado=%0d", nome, atual, esp);
    end
  endtask
  function automatic void modeloReset();
    mEst = 0; mTent = 0; restante = 0; mPrevA = 0; mPrevF = 0;
  endfunction
  // model tracks remaining cycles in the current state rather than an up-counter
  function automatic void modelo();
    bit ea, ef;
    ea = bus.aceitoID && !mPrevA;
    ef = bus.falhaID && !mPrevF;
    mPrevA = bus.aceitoID;
    mPrevF = bus.falhaID;
    if (mEst == 0) begin
      if (bus.inicio) begin mEst = 1; restante = TE; end
    end else begin
      restante--;
      if (mEst == 1) begin
        if (ea && !ef) begin mEst = 2; restante = TA; mTent = 0; end
        else if (ef || restante == 0) begin
          mTent++;
          if (mTent == MAXT) begin mEst = 3; restante = TB; end
          else mEst = 0;
        end
      end else if (mEst == 2) begin
        if (bus.fecharPorta || restante == 0) mEst = 0;
      end else if (restante == 0) begin
        mEst = 0; mTent = 0;
      end
    end
  endfunction
  task automatic entradas(bit i, bit a, bit f, bit c);
    bus.inicio = i; bus.aceitoID = a; bus.falhaID = f; bus.fecharPorta = c;
  endtask
  task automatic ciclo();
    @(posedge clk_27);
    modelo();
    @(negedge clk_27);
    confere("modelo", saida(), esperado(mEst, mTent));
    nHab += int'(bus.habilitaEntrada);
    nTrava += int'(bus.travaAberta);
    nBloq += int'(bus.bloqueado);
  endtask
  task automatic resetar();
    rst_n = 1'b0;
    entradas(0, 0, 0, 0);
    #1;
    confere("reset", saida(), 9'd0);
    repeat (2) @(negedge clk_27);
    modeloReset();
    nHab = 0; nTrava = 0; nBloq = 0;
    rst_n = 1'b1;
  endtask
  task automatic tentativaFalha();
    entradas(1, 0, 0, 0); ciclo();
    entradas(0, 0, 1, 0); ciclo();
    entradas(0, 0, 0, 0);
  endtask
  initial begin
    tabela[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
    tabela[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0};
    tabela[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1};
    tabela[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1};
    tabela[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2};
    tabela[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2};
    tabela[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2};
    tabela[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2};
    tabela[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0};
    tabela[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0};
    tabela[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0};
    tabela[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd1};
    #1;
    resetar();
    for (int i = 0; i < 12; i++) begin
      entradas(tabela[i].inicio, tabela[i].aceito, tabela[i].falha, tabela[i].fechar);
      ciclo();
      confere($sformatf("tabela[%0d]", i), saida(), esperado(int'(tabela[i].est), int'(tabela[i].tent)));
    end
    resetar();
    entradas(1, 0, 0, 0); ciclo();
    entradas(0, 0, 0, 0); repeat (4) ciclo();
    entradas(0, 1, 0, 0); ciclo();
    entradas(0, 0, 0, 0); repeat (15) ciclo();
    confereInt("feliz_habilita", nHab, 5);
    confereInt("feliz_trava", nTrava, 10);
    confereInt("feliz_estado", int'(bus.estado), 0);
    resetar();
    for (int i = 0; i < 3; i++) begin
      tentativaFalha();
      confereInt($sformatf("bloqueio_falhas%0d", i), int'(bus.tentativasFalhas), i + 1);
    end
    confereInt("bloqueio_ativo", int'(bus.bloqueado), 1);
    entradas(1, 0, 0, 0); ciclo();
    entradas(0, 0, 0, 0); repeat (20) ciclo();
    confereInt("bloqueio_ciclos", nBloq, 16);
    confereInt("bloqueio_fim_falhas", int'(bus.tentativasFalhas), 0);
    confereInt("bloqueio_fim_estado", int'(bus.estado), 0);
    resetar();
    entradas(1, 0, 0, 0); ciclo();
    entradas(0, 0, 0, 0); repeat (25) ciclo();
    confereInt("timeout_ciclos", nHab, 20);
    confereInt("timeout_falhas", int'(bus.tentativasFalhas), 1);
    resetar();
    entradas(0, 1, 0, 0); ciclo();
    entradas(1, 1, 0, 0); ciclo();
    entradas(0, 1, 0, 0); repeat (25) ciclo();
    confereInt("antigo_trava", nTrava, 0);
    confereInt("antigo_falhas", int'(bus.tentativasFalhas), 1);
    entradas(0, 0, 0, 0); ciclo();
    resetar();
    entradas(1, 0, 0, 0); ciclo();
    entradas(0, 1, 0, 0); repeat (3) ciclo();
    entradas(0, 1, 0, 1); ciclo();
    confereInt("fechar_trava", int'(bus.travaAberta), 0);
    confereInt("fechar_ciclos", nTrava, 3);
    confereInt("fechar_estado", int'(bus.estado), 0);
    resetar();
    repeat (3) tentativaFalha();
    repeat (3) ciclo();
    confereInt("rst_bloq_antes", int'(bus.bloqueado), 1);
    #2;
    resetar();
    entradas(1, 0, 0, 0); ciclo();
    confereInt("rst_bloq_entrada", int'(bus.estado), 1);
    entradas(0, 0, 0, 0);
    resetar();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) resetar();
      else begin
        bus.inicio = ($urandom_range(3) == 0);
        if ($urandom_range(5) == 0) bus.aceitoID = ~bus.aceitoID;
        if ($urandom_range(8) == 0) bus.falhaID = ~bus.falhaID;
        bus.fecharPorta = ($urandom_range(7) == 0);
        ciclo();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
